// File: rtl/clkdiv_seq.sv
// ---------------------------------------------------------------------------
// clkdiv_seq
// Bring-up controller for the ripple clock divider. It drives the divider's
// active-low reset through a fixed hold/settle sequence. It then counts
// rising edges of one divided-clock tap over a fixed window of reference
// clocks. It reports lock, retries, or sticky failure to link bring-up.
//
// Ports:
//   clk        in   reference clock (also drives the divider)
//   rst        in   synchronous active-high reset
//   start      in   single-cycle pulse, starts/restarts the sequence
//   div_tap    in   divided-clock tap, asynchronous to clk
//   div_rstb   out  active-low divider reset
//   busy       out  high in RESET/SETTLE/MEASURE/CHECK
//   locked     out  last window was within tolerance
//   fail       out  sticky failure (retries exhausted or lock lost)
//   edge_count out  edge count of the most recent completed window
//   retry_cnt  out  retries consumed in the current sequence
//
// Handshake: start is a plain level sampled on each clk edge. It is acted
// on only in IDLE, LOCKED and FAIL, and rst has priority over it.
// All outputs are registered and change together with the state register.
// ---------------------------------------------------------------------------
module clkdiv_seq #(
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 32,
  parameter int WINDOW        = 256,
  parameter int EXP_EDGES     = 16,
  parameter int TOL           = 1,
  parameter int MAX_RETRY     = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_tap,
  output logic             div_rstb,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] edge_count,
  output logic [1:0]       retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_CHECK   = 3'd4,
    S_LOCKED  = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  // A single down-counter times every phase. It is loaded with length-1 on
  // entry, and the phase ends in the cycle where it reads zero.
  localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES)
                          ? ((RST_CYCLES > WINDOW) ? RST_CYCLES : WINDOW)
                          : ((SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW);
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

  localparam logic [PH_W-1:0] RST_LD    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] WIN_LD    = PH_W'(WINDOW - 1);
  localparam logic [1:0]      MAX_R     = 2'(MAX_RETRY);

  // Limits are held one bit wider and signed, so EXP_EDGES < TOL gives a
  // negative lower bound instead of wrapping to a huge value.
  localparam logic signed [CNT_W:0] LO_LIM = (CNT_W+1)'(EXP_EDGES - TOL);
  localparam logic signed [CNT_W:0] HI_LIM = (CNT_W+1)'(EXP_EDGES + TOL);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic [1:0]        retry_q, retry_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              hist_q, hist_d;
  logic              div_rstb_q, div_rstb_d;
  logic              busy_q, busy_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;

  logic              edge_det;
  logic              phase_done;
  logic [CNT_W-1:0]  cnt_inc;

  function automatic logic in_tol(input logic [CNT_W-1:0] c);
    logic signed [CNT_W:0] cs;
    cs = $signed({1'b0, c});
    return (cs >= LO_LIM) && (cs <= HI_LIM);
  endfunction

  // The synchroniser runs in every state. The SETTLE phase is long enough
  // to flush stale history before counting begins.
  always_comb begin
    sync1_d = div_tap;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  assign edge_det   = sync2_q & ~hist_q;
  assign phase_done = (phase_q == '0);
  // The counter saturates at all-ones rather than wrapping.
  assign cnt_inc    = (edge_det && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    edge_count_d = edge_count_q;
    retry_d      = retry_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RESET;
          phase_d = RST_LD;
          retry_d = '0;
        end
      end

      S_RESET: begin
        if (phase_done) begin
          state_d = S_SETTLE;
          phase_d = SETTLE_LD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_SETTLE: begin
        cnt_d = '0;
        if (phase_done) begin
          state_d = S_MEASURE;
          phase_d = WIN_LD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_MEASURE: begin
        // An edge seen in the last window cycle is still counted.
        cnt_d = cnt_inc;
        if (phase_done) begin
          state_d = S_CHECK;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_CHECK: begin
        edge_count_d = cnt_q;
        cnt_d        = '0;
        if (in_tol(cnt_q)) begin
          state_d = S_LOCKED;
          phase_d = WIN_LD;
        end else if (retry_q < MAX_R) begin
          retry_d = retry_q + 1'b1;
          state_d = S_RESET;
          phase_d = RST_LD;
        end else begin
          state_d = S_FAIL;
        end
      end

      S_LOCKED: begin
        if (start) begin
          state_d = S_RESET;
          phase_d = RST_LD;
          retry_d = '0;
          cnt_d   = '0;
        end else if (phase_done) begin
          // Window boundary: publish, re-arm with no gap, and judge.
          edge_count_d = cnt_inc;
          cnt_d        = '0;
          phase_d      = WIN_LD;
          if (!in_tol(cnt_inc)) begin
            state_d = S_FAIL;
          end
        end else begin
          cnt_d   = cnt_inc;
          phase_d = phase_q - 1'b1;
        end
      end

      S_FAIL: begin
        if (start) begin
          state_d = S_RESET;
          phase_d = RST_LD;
          retry_d = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state, so they are registered and
  // change in step with the state register.
  always_comb begin
    div_rstb_d = !((state_d == S_IDLE) || (state_d == S_RESET));
    busy_d     = (state_d == S_RESET) || (state_d == S_SETTLE) ||
                 (state_d == S_MEASURE) || (state_d == S_CHECK);
    locked_d   = (state_d == S_LOCKED);
    fail_d     = (state_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      cnt_q        <= '0;
      edge_count_q <= '0;
      retry_q      <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      div_rstb_q   <= 1'b0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      edge_count_q <= edge_count_d;
      retry_q      <= retry_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      div_rstb_q   <= div_rstb_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign div_rstb   = div_rstb_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign edge_count = edge_count_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_clkdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_seq
// Bench for clkdiv_seq with default parameters. k counts clk edges since the
// edge that sampled start (k=0 is the first RESET cycle). The tap generator
// derives div_tap from k, so every window count is known in advance.
// Expected outputs are packed as {busy,locked,fail,div_rstb,retry,edges}.
// ---------------------------------------------------------------------------
module tb_clkdiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        div_tap;
  logic        div_rstb;
  logic        busy;
  logic        locked;
  logic        fail;
  logic [15:0] edge_count;
  logic [1:0]  retry_cnt;

  clkdiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .div_tap    (div_tap),
    .div_rstb   (div_rstb),
    .busy       (busy),
    .locked     (locked),
    .fail       (fail),
    .edge_count (edge_count),
    .retry_cnt  (retry_cnt)
  );

  // ---------------- clock / reset / tap generation ----------------
  always #5 clk = ~clk;

  int k         = 0;
  bit sync_k    = 1'b0;
  int tap_mode  = 0;
  int burst_n   = 0;

  always @(posedge clk) begin
    if (start && sync_k) k = 0;
    else                 k = k + 1;
  end

  // 0: stuck low, 1: clk/16, 2: burst_n pulses of period 8 from k=60,
  // 3: low until k=297 then clk/16, 4: clk/16 until k=400 then low.
  always @(negedge clk) begin
    case (tap_mode)
      0:       div_tap = 1'b0;
      1:       div_tap = (k % 16) < 8;
      2:       div_tap = (k >= 60) && (k < 60 + 8 * burst_n) && (((k - 60) % 8) < 4);
      3:       div_tap = (k >= 297) && ((k % 16) < 8);
      default: div_tap = (k < 400) && ((k % 16) < 8);
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [31:0] pk(input logic b, input logic l, input logic f,
                                     input logic r, input logic [1:0] rc,
                                     input logic [15:0] ec);
    return {10'b0, b, l, f, r, rc, ec};
  endfunction

  function automatic logic [31:0] outs();
    return pk(busy, locked, fail, div_rstb, retry_cnt, edge_count);
  endfunction

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: got %h, no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_mis++;
        $display("FAIL %s: got %h want %h", name, act, e);
      end
    end
  endtask

  task automatic expect_now(input string name, input logic [31:0] e);
    exp_q.push_back(e);
    sb_check(name, outs());
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input bit sync);
    @(negedge clk);
    start  = 1'b1;
    sync_k = sync;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits until negedge with k == target; an overrun counts as a failure.
  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        n_cmp++;
        n_mis++;
        $display("FAIL wait_k: k=%0d never reached %0d", k, target);
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    int          mode;
    int          nb;
    int          chk_k;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  int low_cnt;
  int rise_cnt;
  logic prev_rstb;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    div_tap = 1'b0;

    tbl[0] = '{"nominal_16",  1, 0,  297, pk(0, 1, 0, 1, 2'd0, 16'd16)};
    tbl[1] = '{"tol_15",      2, 15, 297, pk(0, 1, 0, 1, 2'd0, 16'd15)};
    tbl[2] = '{"tol_17",      2, 17, 297, pk(0, 1, 0, 1, 2'd0, 16'd17)};
    tbl[3] = '{"tol_14_retry",2, 14, 297, pk(1, 0, 0, 0, 2'd1, 16'd14)};
    tbl[4] = '{"tol_18_retry",2, 18, 297, pk(1, 0, 0, 0, 2'd1, 16'd18)};
    tbl[5] = '{"recover_2nd", 3, 0,  594, pk(0, 1, 0, 1, 2'd1, 16'd16)};

    // Reset values.
    do_reset();
    expect_now("reset_vals", pk(0, 0, 0, 0, 2'd0, 16'd0));

    // Nominal timing detail.
    tap_mode = 1;
    pulse_start(1'b1);
    wait_k(0);   expect_now("nom_reset_k0",  pk(1, 0, 0, 0, 2'd0, 16'd0));
    wait_k(7);   expect_now("nom_reset_k7",  pk(1, 0, 0, 0, 2'd0, 16'd0));
    wait_k(8);   expect_now("nom_settle_k8", pk(1, 0, 0, 1, 2'd0, 16'd0));
    wait_k(296); expect_now("nom_check",     pk(1, 0, 0, 1, 2'd0, 16'd0));
    wait_k(297); expect_now("nom_locked",    pk(0, 1, 0, 1, 2'd0, 16'd16));

    // Table rows: expectation queued when stimulus is driven.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      tap_mode = tbl[i].mode;
      burst_n  = tbl[i].nb;
      exp_q.push_back(tbl[i].exp);
      pulse_start(1'b1);
      wait_k(tbl[i].chk_k);
      sb_check(tbl[i].name, outs());
    end

    // Retry exhaustion with tap stuck low.
    do_reset();
    tap_mode  = 0;
    pulse_start(1'b1);
    low_cnt   = 0;
    rise_cnt  = 0;
    prev_rstb = 1'b0;
    for (int i = 0; i <= 890; i++) begin
      wait_k(i);
      if (!div_rstb) low_cnt++;
      if (div_rstb && !prev_rstb) rise_cnt++;
      prev_rstb = div_rstb;
    end
    expect_now("exh_last_check", pk(1, 0, 0, 1, 2'd2, 16'd0));
    wait_k(891);
    expect_now("exh_fail",       pk(0, 0, 1, 1, 2'd2, 16'd0));
    exp_q.push_back(32'd24);
    sb_check("exh_rstb_low_cycles", 32'(low_cnt));
    exp_q.push_back(32'd3);
    sb_check("exh_rstb_pulses", 32'(rise_cnt));

    // Loss of lock: tap stops at k=400; 6 edges land in the first
    // monitoring window (k 297..552), which ends at k=552.
    do_reset();
    tap_mode = 4;
    pulse_start(1'b1);
    wait_k(297); expect_now("lol_locked",   pk(0, 1, 0, 1, 2'd0, 16'd16));
    wait_k(552); expect_now("lol_hold",     pk(0, 1, 0, 1, 2'd0, 16'd16));
    wait_k(553); expect_now("lol_fail",     pk(0, 0, 1, 1, 2'd0, 16'd6));
    wait_k(560); expect_now("lol_sticky",   pk(0, 0, 1, 1, 2'd0, 16'd6));
    tap_mode = 1;
    pulse_start(1'b1);
    expect_now("lol_restart", pk(1, 0, 0, 0, 2'd0, 16'd6));
    wait_k(297); expect_now("lol_relock",   pk(0, 1, 0, 1, 2'd0, 16'd16));

    // start during MEASURE is ignored.
    do_reset();
    tap_mode = 1;
    pulse_start(1'b1);
    wait_k(100);
    pulse_start(1'b0);
    wait_k(296); expect_now("ign_check",  pk(1, 0, 0, 1, 2'd0, 16'd0));
    wait_k(297); expect_now("ign_locked", pk(0, 1, 0, 1, 2'd0, 16'd16));

    // start and rst together from LOCKED: rst wins, stays in IDLE.
    start  = 1'b1;
    rst    = 1'b1;
    sync_k = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    expect_now("start_rst_now", pk(0, 0, 0, 0, 2'd0, 16'd0));
    repeat (5) @(negedge clk);
    expect_now("start_rst_idle", pk(0, 0, 0, 0, 2'd0, 16'd0));

    // rst mid-SETTLE.
    pulse_start(1'b1);
    wait_k(20);
    expect_now("settle_pre", pk(1, 0, 0, 1, 2'd0, 16'd0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_now("settle_rst", pk(0, 0, 0, 0, 2'd0, 16'd0));
    repeat (3) @(negedge clk);
    expect_now("settle_idle", pk(0, 0, 0, 0, 2'd0, 16'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/clkdiv_seq.md
Name: clkdiv_seq

Overview:
- Control stage directly upstream of the ripple clock divider.
- Generates the divider's active-low reset (`div_rstb`) with a fixed hold-and-settle sequence.
- Then measures one divided-clock output tap against the reference clock and reports lock or failure to the link bring-up logic.
- Runs entirely in the reference clock domain; the divided-clock tap is treated as asynchronous and synchronised internally.

Parameters:
- RST_CYCLES, 8: cycles `div_rstb` is held low per attempt (≥1).
- SETTLE_CYCLES, 32: cycles after reset release before measuring (≥1).
- WINDOW, 256: measurement window length in `clk` cycles (≥2).
- EXP_EDGES, 16: expected rising edges of the tap per window.
- TOL, 1: allowed |count − EXP_EDGES| for pass.
- MAX_RETRY, 2: re-attempts after a failed initial check before declaring FAIL.
- CNT_W, 16: width of the edge counter and `edge_count` output.

Ports:
- clk, input, 1: reference clock (same net that drives the divider input).
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse; begins or restarts the sequence.
- div_tap, input, 1: selected divided-clock output, asynchronous to the sampling flops.
- div_rstb, output, 1: active-low reset to the divider.
- busy, output, 1: sequence in progress (RESET/SETTLE/MEASURE/CHECK).
- locked, output, 1: last check passed; remains set while monitoring passes.
- fail, output, 1: sticky failure (retries exhausted or loss of lock).
- edge_count, output, CNT_W: edge count from the most recent completed window.
- retry_cnt, output, 2: retries consumed in the current sequence.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE; `div_rstb`=0, `busy`=0, `locked`=0, `fail`=0, `edge_count`=0, `retry_cnt`=0.
  - Synchroniser and counters cleared.
  - `rst` mid-sequence aborts immediately to these values.
- Synchroniser and edge detect:
  - `div_tap` passes through a 2-flop synchroniser, then a history flop.
  - Edge = sync_q & ~hist_q.
  - A tap rise is counted 3 clk edges after it is sampled.
  - Tap frequency ≤ clk/4 is guaranteed to count exactly; faster taps are out of scope.
- IDLE: `div_rstb`=0. `start` → RESET.
- RESET:
  - `div_rstb`=0 for exactly RST_CYCLES cycles, counted from the first cycle in RESET.
  - Then → SETTLE, with `div_rstb`=1 from the first SETTLE cycle.
- SETTLE:
  - Lasts SETTLE_CYCLES cycles; synchroniser history is flushed here.
  - Then → MEASURE with the edge counter at 0.
- MEASURE:
  - Lasts WINDOW cycles; the counter increments on each edge.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
  - An edge detected in the last MEASURE cycle is counted.
- CHECK (one cycle):
  - `edge_count` ← counter.
  - Pass if EXP_EDGES−TOL ≤ count ≤ EXP_EDGES+TOL; the signed compare is done at CNT_W+1 bits so that EXP_EDGES<TOL does not underflow.
  - Pass → LOCKED, `locked`=1 from the next cycle.
  - Fail with `retry_cnt` < MAX_RETRY → `retry_cnt`+1, → RESET.
  - Fail otherwise → FAIL.
- LOCKED:
  - `busy`=0, `div_rstb`=1.
  - Back-to-back WINDOW-length windows with no gap; each window end updates `edge_count`.
  - An out-of-tolerance window → FAIL with `locked`=0 and `fail`=1 on the next cycle.
- FAIL: `div_rstb`=1, `fail`=1 sticky, `locked`=0. Only `start` or `rst` leaves this state.
- `start` handling:
  - In LOCKED or FAIL: clears `fail`, `locked`, `retry_cnt` and enters RESET next cycle.
  - While `busy`: ignored.
  - Coinciding with `rst`: `rst` wins.
- `busy`=1 exactly in RESET/SETTLE/MEASURE/CHECK.
- Latency from `start` to `locked` on first-try pass: 1 + RST_CYCLES + SETTLE_CYCLES + WINDOW + 1 cycles (298 with defaults).

Test Plan:
- Nominal lock: defaults, `div_tap` = clk/16 square wave, pulse `start`.
  - `div_rstb` low 8 cycles.
  - `locked`=1 at cycle 298.
  - `edge_count`=16, `fail`=0, `retry_cnt`=0.
- Tolerance edges: tap giving 15 edges → `locked`; giving 17 → `locked`; giving 14 → retry.
- Retry exhaustion: `div_tap` held 0.
  - Three RESET pulses of `div_rstb` observed.
  - `retry_cnt`=2; `fail`=1 after 3×(8+32+256+1) cycles; `edge_count`=0.
- Recovery on retry: tap stuck 0 for the first attempt, clk/16 from the second.
  - `locked`=1 with `retry_cnt`=1.
- Loss of lock: after lock, stop tap.
  - At the end of the current window: `locked`→0, `fail`=1, `edge_count`≤15.
  - Then `start` → re-sequence to `locked`.
- Control corners:
  - `start` during MEASURE is ignored (timing unchanged).
  - `rst` asserted mid-SETTLE → all outputs at reset values the next cycle.
  - `start` and `rst` in the same cycle → IDLE.
